// File: rtl/prog_pkg.sv
// Shared definitions for the loadable program memory.
//   prog_state_t : controller states (CLEAR wipes storage, RUN serves fetches,
//                  LOAD accepts a byte-serial program image)
//   NOP          : fill bit for cleared words; replicated to the instruction width
//   PSIZE_DEF / ISIZE_DEF : default address and instruction widths
package prog_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } prog_state_t;

  // A NOP is the all-zeros word.
  localparam logic NOP = 1'b0;

  localparam int PSIZE_DEF = 8;
  localparam int ISIZE_DEF = 8;

endpackage

// File: rtl/prog_store.sv
// Program storage: 2^Psize x Isize array, one synchronous write port and one
// registered read port. The read register holds its value when re_i is low
// and is the only storage element with a reset.
//   clk_i, rst_i            : clock, synchronous active-high reset (read register)
//   we_i, waddr_i, wdata_i  : write port
//   re_i, raddr_i, rdata_o  : registered read port
module prog_store
  import prog_pkg::*;
#(
  parameter int Psize = PSIZE_DEF,
  parameter int Isize = ISIZE_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [Psize-1:0] waddr_i,
  input  logic [Isize-1:0] wdata_i,
  input  logic             re_i,
  input  logic [Psize-1:0] raddr_i,
  output logic [Isize-1:0] rdata_o
);

  localparam int DEPTH = 1 << Psize;

  logic [Isize-1:0] mem [DEPTH];
  logic [Isize-1:0] rdata_q;

  // Contents are wiped by the controller's CLEAR sweep, not by reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_ram.sv
// Loadable program memory for the single-stage processor.
// After reset every word is swept to NOP (CLEAR). In RUN, the processor fetches
// through a registered read port. A load streams ld_len words into addresses
// 0.. through a valid/ready port. The processor is held off while clearing or loading.
//   Clock, Reset               : clock, synchronous active-high reset
//   address, fetch_en          : fetch request (RUN only)
//   I, I_valid                 : registered instruction, valid one cycle after fetch
//   cpu_hold                   : high in CLEAR and LOAD
//   ld_start, ld_len           : start a load of ld_len words (RUN only)
//   ld_data, ld_valid, ld_ready: load word handshake (ready exactly in LOAD)
//   ld_done                    : one-cycle pulse in the first RUN cycle after a load
module prog_ram
  import prog_pkg::*;
#(
  parameter int Psize = PSIZE_DEF,
  parameter int Isize = ISIZE_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [Psize-1:0] address,
  input  logic             fetch_en,
  output logic [Isize-1:0] I,
  output logic             I_valid,
  output logic             cpu_hold,
  input  logic             ld_start,
  input  logic [Psize:0]   ld_len,
  input  logic [Isize-1:0] ld_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic             ld_done
);

  localparam logic [Psize:0]   DEPTH    = {1'b1, {Psize{1'b0}}};
  localparam logic [Psize:0]   REM_ONE  = (Psize+1)'(1);
  localparam logic [Psize-1:0] PTR_ONE  = Psize'(1);
  localparam logic [Psize-1:0] PTR_LAST = '1;

  prog_state_t      state_q;
  logic [Psize-1:0] clr_ptr_q;
  logic [Psize-1:0] wptr_q;
  logic [Psize:0]   rem_q;
  logic [Psize:0]   rem_d;
  logic             i_valid_q;
  logic             ld_done_q;

  logic             we;
  logic [Psize-1:0] waddr;
  logic [Isize-1:0] wdata;
  logic             re;
  logic             accept;

  // A load longer than the memory is clipped to one full pass.
  assign rem_d  = (ld_len > DEPTH) ? DEPTH : ld_len;
  assign accept = (state_q == LOAD) && ld_valid;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      wptr_q    <= '0;
      rem_q     <= '0;
      i_valid_q <= 1'b0;
      ld_done_q <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      i_valid_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + PTR_ONE;
          if (clr_ptr_q == PTR_LAST) state_q <= RUN;
        end
        RUN: begin
          i_valid_q <= fetch_en;
          if (ld_start) begin
            if (ld_len == '0) begin
              ld_done_q <= 1'b1;
            end else begin
              rem_q   <= rem_d;
              wptr_q  <= '0;
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wptr_q <= wptr_q + PTR_ONE;
            rem_q  <= rem_q - REM_ONE;
            // Last word: done pulse lines up with the first RUN cycle.
            if (rem_q == REM_ONE) begin
              state_q   <= RUN;
              ld_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Reads happen only in RUN and writes only in CLEAR/LOAD, so the ports never collide.
  always_comb begin
    we    = 1'b0;
    waddr = clr_ptr_q;
    wdata = {Isize{NOP}};
    if (state_q == CLEAR) begin
      we = 1'b1;
    end else if (accept) begin
      we    = 1'b1;
      waddr = wptr_q;
      wdata = ld_data;
    end
  end

  assign re = (state_q == RUN) && fetch_en;

  prog_store #(
    .Psize(Psize),
    .Isize(Isize)
  ) u_store (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .re_i   (re),
    .raddr_i(address),
    .rdata_o(I)
  );

  assign I_valid  = i_valid_q;
  assign ld_done  = ld_done_q;
  assign cpu_hold = (state_q != RUN);
  assign ld_ready = (state_q == LOAD);

endmodule
